// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, flag indices and FSM states
// for the registered ALU pipeline stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_ADC  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier,
// one partial-product step per cycle, WIDTH steps.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // done is held for one cycle after the final step
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH));
  assign busy_o    = busy_q;
  assign product_o = acc_q;

  // next-state: load on start, step while busy, release after done
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (done_o) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU stage with valid/ready on
// both sides, flags, carry chain and iterative MUL.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);
  import alu_pkg::*;

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;
  logic               carry_q, carry_d;

  logic               accept, is_mul;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   res;
  logic               c, v, e, upd_c;
  logic [WIDTH:0]     sum, ext;
  logic [SW-1:0]      sh;

  assign in_ready  = (state_q == S_IDLE) && !mul_busy
                  && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (MUL_EN != 0) && (op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign sh        = b[SW-1:0];

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

  if (MUL_EN != 0) begin : g_mul
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (a),
      .b_i       (b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // single-cycle op decode; MUL and D-F fall to illegal
  always_comb begin
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    e     = 1'b0;
    upd_c = 1'b0;
    sum   = '0;
    ext   = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a} + {1'b0, b}
            + {{WIDTH{1'b0}}, (op == OP_ADC) && carry_q};
        res   = sum[M:0];
        c     = sum[WIDTH];
        v     = (a[M] == b[M]) && (res[M] != a[M]);
        upd_c = 1'b1;
      end
      OP_SUB: begin
        sum   = {1'b0, a} - {1'b0, b};
        res   = sum[M:0];
        c     = sum[WIDTH];
        v     = (a[M] != b[M]) && (res[M] != a[M]);
        upd_c = 1'b1;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_SHL: begin
        ext = {1'b0, a} << sh;
        res = ext[M:0];
        c   = ext[WIDTH];
      end
      OP_SHR: begin
        ext = {a, 1'b0} >> sh;
        res = ext[WIDTH:1];
        c   = ext[0];
      end
      OP_SRA: begin
        ext = $signed({a, 1'b0}) >>> sh;
        res = ext[WIDTH:1];
        c   = ext[0];
      end
      default: e = 1'b1;
    endcase
  end

  // FSM next-state and output-register loads
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    err_d       = err_q;
    carry_d     = carry_q;
    if (out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          state_d = S_MUL;
        end else if (accept) begin
          out_valid_d     = 1'b1;
          result_d        = res;
          err_d           = e;
          flags_d         = '0;
          if (!e) begin
            flags_d[FLAG_N] = res[M];
            flags_d[FLAG_Z] = (res == '0);
            flags_d[FLAG_C] = c;
            flags_d[FLAG_V] = v;
          end
          if (upd_c) carry_d = c;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d         = S_IDLE;
          out_valid_d     = 1'b1;
          result_d        = mul_prod[M:0];
          err_d           = 1'b0;
          flags_d         = '0;
          flags_d[FLAG_N] = mul_prod[M];
          flags_d[FLAG_Z] = (mul_prod[M:0] == '0);
          flags_d[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
      carry_q     <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench with an arithmetic
// reference model, directed spec cases and random ops.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] flags;
  logic       err;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cq = 0;
  bit rnd = 1'b0;
  logic [12:0] q[$];

  alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int sx8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // expected {result, N Z C V, err}; tracks carry
  function automatic logic [12:0] model(
    input int o, input int x, input int y);
    int r, c, v, e, s, sh, ss;
    r = 0; c = 0; v = 0; e = 0;
    sh = y % 8;
    case (o)
      0, 11: begin
        s  = x + y + ((o == 11) ? cq : 0);
        ss = sx8(x) + sx8(y) + ((o == 11) ? cq : 0);
        r = s % 256; c = (s > 255);
        v = (ss > 127 || ss < -128); cq = c;
      end
      1: begin
        r = (x - y + 256) % 256; c = (x < y);
        ss = sx8(x) - sx8(y);
        v = (ss > 127 || ss < -128); cq = c;
      end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - (x & y);
      6: r = 255 - (x | y);
      7: r = 255 - (x ^ y);
      8: begin
        r = (x << sh) % 256;
        c = sh ? (x >> (8 - sh)) & 1 : 0;
      end
      9: begin
        r = x >> sh;
        c = sh ? (x >> (sh - 1)) & 1 : 0;
      end
      10: begin
        r = (sx8(x) >>> sh) & 255;
        c = sh ? (sx8(x) >>> (sh - 1)) & 1 : 0;
      end
      12: begin
        s = x * y; r = s % 256; c = (s > 255);
      end
      default: e = 1;
    endcase
    if (e) return 13'h001;
    return {r[7:0], r >= 128, r == 0, c[0], v[0], 1'b0};
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input int o, input int x,
                       input int y);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o[3:0]; a = x[7:0]; b = y[7:0];
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      q.push_back(model(o, x, y));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // out_ready jitter, away from the sampling edge
  initial forever begin
    @(posedge clk); #2;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: hold stability and scoreboard compare
  initial begin
    bit hold = 1'b0;
    logic [12:0] hv, ex;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          checks++;
          if (!out_valid || {result, flags, err} !== hv) begin
            errors++;
            $display("FAIL hold: got v=%0b %0h expected %0h",
                     out_valid, {result, flags, err}, hv);
          end
        end
        if (out_valid && !out_ready) begin
          hold = 1'b1;
          hv = {result, flags, err};
          chk("hold_in_ready", in_ready, 0);
        end else begin
          hold = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            ex = q.pop_front();
            pops++;
            chk("scoreboard", {result, flags, err}, ex);
          end
        end
      end
    end
  end

  initial begin
    int k, t0, p0;
    bit ok, stale;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    cq = 0;

    issue(0, 8'hFF, 8'h01);
    chk("add_lat_valid", out_valid, 1);
    chk("add_result", result, 8'h00);
    chk("add_flags", flags, 4'b0110);
    issue(1, 8'h80, 8'h01);
    chk("sub_ovf_result", result, 8'h7F);
    chk("sub_ovf_flags", flags, 4'b0001);
    issue(1, 8'h01, 8'h02);
    chk("sub_brw_result", result, 8'hFF);
    chk("sub_brw_flags", flags, 4'b1010);
    issue(0, 8'hFF, 8'h01);
    issue(11, 8'h01, 8'h01);
    chk("adc_result", result, 8'h03);
    issue(2, 8'h5A, 8'h0F);
    issue(11, 8'h00, 8'h00);
    chk("adc_zero_result", result, 8'h00);
    issue(8, 8'h81, 8'h01);
    chk("shl_result", result, 8'h02);
    chk("shl_flags", flags, 4'b0010);
    issue(10, 8'h90, 8'h03);
    chk("sra_result", result, 8'hF2);
    chk("sra_flags", flags, 4'b1000);
    issue(9, 8'h03, 8'h09);
    chk("shr_wrap_result", result, 8'h01);
    issue(14, 8'h12, 8'h34);
    chk("illegal_result", result, 8'h00);
    chk("illegal_err", err, 1);

    drain();
    out_ready = 1'b0;
    issue(12, 8'h10, 8'h11);
    k = 0; ok = 1'b1;
    while (!out_valid && k < 40) begin
      if (in_ready) ok = 1'b0;
      @(posedge clk); #1; k++;
    end
    chk("mul_latency", k, 9);
    chk("mul_busy_in_ready", ok, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mul_hold_result", result, 8'h10);
      chk("mul_hold_in_ready", in_ready, 0);
    end
    chk("mul_flags", flags, 4'b0010);
    out_ready = 1'b1;

    drain();
    t0 = $time; p0 = pops;
    repeat (6) issue(0, $urandom_range(0, 255),
                     $urandom_range(0, 255));
    chk("b2b_cycles", ($time - t0) / 10, 6);
    @(negedge clk); #1;
    chk("b2b_pops", pops - p0, 6);

    drain();
    issue(12, 8'h37, 8'hB5);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("midmul_rst_valid", out_valid, 0);
    q.delete();
    cq = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("midmul_in_ready", in_ready, 1);
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("midmul_no_stale", stale, 0);
    issue(11, 8'h00, 8'h00);

    rnd = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 4) == 0) @(posedge clk);
      issue($urandom_range(0, 15), $urandom_range(0, 255),
            $urandom_range(0, 255));
    end
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
